// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID/EX stage and its load-use hazard logic.
package hazard_pkg;

  typedef struct packed {
    logic       RegW;
    logic       MemRead;
    logic       MemW;
    logic [3:0] ALUCtrl;
    logic       ALUSrc;
  } ctrl_t;

  localparam ctrl_t      CTRL_NOP = '0;
  localparam logic [4:0] REG_ZERO = '0;

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use hazard detect: a load in EX whose destination is read
// by the instruction in decode must stall decode, unless a flush kills decode.
module load_use_detect #(
  parameter int WIDTH = 5
) (
  input  logic             ValidE,
  input  logic             MemReadE,
  input  logic [WIDTH-1:0] WriteRegE,
  input  logic             ValidD,
  input  logic [WIDTH-1:0] RegS1D,
  input  logic [WIDTH-1:0] RegS2D,
  input  logic             UsesS1D,
  input  logic             UsesS2D,
  input  logic             FlushE,
  output logic             LoadUse,
  output logic             StallD
);

  logic matchS1;
  logic matchS2;

  assign matchS1 = UsesS1D && (RegS1D == WriteRegE);
  assign matchS2 = UsesS2D && (RegS2D == WriteRegE);

  // x0 is never a real producer, so a load targeting it cannot create a hazard.
  assign LoadUse = ValidE && MemReadE && ValidD && (WriteRegE != '0) && (matchS1 || matchS2);
  assign StallD  = LoadUse && !FlushE;

endmodule

// File: rtl/id_ex_stage.sv
// Decode/Execute pipeline register with load-use bubble insertion, branch flush
// and a saturating count of load-use stall cycles.
module id_ex_stage
  import hazard_pkg::*;
#(
  parameter int WIDTH      = 5,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ValidD,
  input  logic [WIDTH-1:0]      RegS1D,
  input  logic [WIDTH-1:0]      RegS2D,
  input  logic                  UsesS1D,
  input  logic                  UsesS2D,
  input  logic [WIDTH-1:0]      WriteRegD,
  input  logic [DATA_WIDTH-1:0] RD1D,
  input  logic [DATA_WIDTH-1:0] RD2D,
  input  logic [DATA_WIDTH-1:0] ImmD,
  input  logic [DATA_WIDTH-1:0] PCD,
  input  logic                  RegWD,
  input  logic                  MemReadD,
  input  logic                  MemWD,
  input  logic [3:0]            ALUCtrlD,
  input  logic                  ALUSrcD,
  input  logic                  FlushE,
  output logic                  ValidE,
  output logic [WIDTH-1:0]      RegS1E,
  output logic [WIDTH-1:0]      RegS2E,
  output logic [WIDTH-1:0]      WriteRegE,
  output logic [DATA_WIDTH-1:0] RD1E,
  output logic [DATA_WIDTH-1:0] RD2E,
  output logic [DATA_WIDTH-1:0] ImmE,
  output logic [DATA_WIDTH-1:0] PCE,
  output logic                  RegWE,
  output logic                  MemReadE,
  output logic                  MemWE,
  output logic [3:0]            ALUCtrlE,
  output logic                  ALUSrcE,
  output logic                  StallD,
  output logic [CNT_WIDTH-1:0]  StallCount
);

  ctrl_t ctrlE;
  ctrl_t ctrlCap;
  logic  loadUse;
  logic  bubble;

  load_use_detect #(.WIDTH(WIDTH)) uDetect (
    .ValidE    (ValidE),
    .MemReadE  (ctrlE.MemRead),
    .WriteRegE (WriteRegE),
    .ValidD    (ValidD),
    .RegS1D    (RegS1D),
    .RegS2D    (RegS2D),
    .UsesS1D   (UsesS1D),
    .UsesS2D   (UsesS2D),
    .FlushE    (FlushE),
    .LoadUse   (loadUse),
    .StallD    (StallD)
  );

  assign bubble = FlushE || loadUse;

  // Invalid decode slots carry no side effects; writes to x0 are dropped here
  // so the forwarding unit never has to special-case it.
  always_comb begin
    ctrlCap = CTRL_NOP;
    if (ValidD) begin
      ctrlCap.RegW    = RegWD && (WriteRegD != '0);
      ctrlCap.MemRead = MemReadD;
      ctrlCap.MemW    = MemWD;
      ctrlCap.ALUCtrl = ALUCtrlD;
      ctrlCap.ALUSrc  = ALUSrcD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      ValidE    <= 1'b0;
      RegS1E    <= '0;
      RegS2E    <= '0;
      WriteRegE <= '0;
      RD1E      <= '0;
      RD2E      <= '0;
      ImmE      <= '0;
      PCE       <= '0;
      ctrlE     <= CTRL_NOP;
    end else begin
      ValidE    <= ValidD;
      RegS1E    <= RegS1D;
      RegS2E    <= RegS2D;
      WriteRegE <= WriteRegD;
      RD1E      <= RD1D;
      RD2E      <= RD2D;
      ImmE      <= ImmD;
      PCE       <= PCD;
      ctrlE     <= ctrlCap;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      StallCount <= '0;
    end else if (StallD && (StallCount != '1)) begin
      StallCount <= StallCount + 1'b1;
    end
  end

  assign RegWE    = ctrlE.RegW;
  assign MemReadE = ctrlE.MemRead;
  assign MemWE    = ctrlE.MemW;
  assign ALUCtrlE = ctrlE.ALUCtrl;
  assign ALUSrcE  = ctrlE.ALUSrc;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, capture, load-use stall, flush priority,
// x0 handling and counter saturation (on a narrow-counter second instance).
module tb_id_ex_stage;

  logic        clk;
  logic        rst;
  logic        ValidD;
  logic [4:0]  RegS1D, RegS2D, WriteRegD;
  logic        UsesS1D, UsesS2D;
  logic [31:0] RD1D, RD2D, ImmD, PCD;
  logic        RegWD, MemReadD, MemWD, ALUSrcD, FlushE;
  logic [3:0]  ALUCtrlD;

  logic        ValidE, RegWE, MemReadE, MemWE, ALUSrcE, StallD;
  logic [4:0]  RegS1E, RegS2E, WriteRegE;
  logic [31:0] RD1E, RD2E, ImmE, PCE;
  logic [3:0]  ALUCtrlE;
  logic [15:0] StallCount;

  logic        sValidE, sRegWE, sMemReadE, sMemWE, sALUSrcE, sStallD;
  logic [4:0]  sRegS1E, sRegS2E, sWriteRegE;
  logic [31:0] sRD1E, sRD2E, sImmE, sPCE;
  logic [3:0]  sALUCtrlE;
  logic [3:0]  sStallCount;

  int nChecks = 0;
  int nPass   = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .ValidD(ValidD), .RegS1D(RegS1D), .RegS2D(RegS2D),
    .UsesS1D(UsesS1D), .UsesS2D(UsesS2D), .WriteRegD(WriteRegD),
    .RD1D(RD1D), .RD2D(RD2D), .ImmD(ImmD), .PCD(PCD), .RegWD(RegWD),
    .MemReadD(MemReadD), .MemWD(MemWD), .ALUCtrlD(ALUCtrlD), .ALUSrcD(ALUSrcD),
    .FlushE(FlushE), .ValidE(ValidE), .RegS1E(RegS1E), .RegS2E(RegS2E),
    .WriteRegE(WriteRegE), .RD1E(RD1E), .RD2E(RD2E), .ImmE(ImmE), .PCE(PCE),
    .RegWE(RegWE), .MemReadE(MemReadE), .MemWE(MemWE), .ALUCtrlE(ALUCtrlE),
    .ALUSrcE(ALUSrcE), .StallD(StallD), .StallCount(StallCount)
  );

  id_ex_stage #(.CNT_WIDTH(4)) dutSat (
    .clk(clk), .rst(rst), .ValidD(ValidD), .RegS1D(RegS1D), .RegS2D(RegS2D),
    .UsesS1D(UsesS1D), .UsesS2D(UsesS2D), .WriteRegD(WriteRegD),
    .RD1D(RD1D), .RD2D(RD2D), .ImmD(ImmD), .PCD(PCD), .RegWD(RegWD),
    .MemReadD(MemReadD), .MemWD(MemWD), .ALUCtrlD(ALUCtrlD), .ALUSrcD(ALUSrcD),
    .FlushE(FlushE), .ValidE(sValidE), .RegS1E(sRegS1E), .RegS2E(sRegS2E),
    .WriteRegE(sWriteRegE), .RD1E(sRD1E), .RD2E(sRD2E), .ImmE(sImmE), .PCE(sPCE),
    .RegWE(sRegWE), .MemReadE(sMemReadE), .MemWE(sMemWE), .ALUCtrlE(sALUCtrlE),
    .ALUSrcE(sALUSrcE), .StallD(sStallD), .StallCount(sStallCount)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    if (obs === exp) nPass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic clearD();
    ValidD = 0; RegS1D = 0; RegS2D = 0; UsesS1D = 0; UsesS2D = 0; WriteRegD = 0;
    RD1D = 0; RD2D = 0; ImmD = 0; PCD = 0; RegWD = 0; MemReadD = 0; MemWD = 0;
    ALUCtrlD = 0; ALUSrcD = 0; FlushE = 0;
  endtask

  // one posedge, then return at the following negedge with inputs still held
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic driveLoad(input logic [4:0] rd);
    clearD();
    ValidD = 1; MemReadD = 1; RegWD = 1; WriteRegD = rd;
  endtask

  task automatic driveUser(input logic [4:0] rs1);
    clearD();
    ValidD = 1; UsesS1D = 1; RegS1D = rs1; WriteRegD = 5'd12; RegWD = 1;
  endtask

  task automatic doStall();
    driveLoad(5'd7);
    step();
    driveUser(5'd7);
    #1;
    step();
  endtask

  initial begin
    clearD();
    rst = 1;
    @(negedge clk);
    // 1. reset with random D inputs
    ValidD = 1; RegS1D = 5'($urandom_range(0, 31)); RegS2D = 5'($urandom_range(0, 31));
    WriteRegD = 5'($urandom_range(1, 31)); RD1D = $urandom; PCD = $urandom;
    RegWD = 1; MemReadD = 1; UsesS1D = 1;
    step();
    step();
    check("rst_ValidE", ValidE, 0);
    check("rst_WriteRegE", WriteRegE, 0);
    check("rst_RegWE", RegWE, 0);
    check("rst_MemReadE", MemReadE, 0);
    check("rst_RD1E", RD1E, 0);
    check("rst_PCE", PCE, 0);
    check("rst_StallD", StallD, 0);
    check("rst_StallCount", StallCount, 0);
    rst = 0;

    // 2. normal capture
    clearD();
    ValidD = 1; RegS1D = 1; RegS2D = 9; WriteRegD = 9; RD1D = 32'h11; RD2D = 32'h22;
    ImmD = 32'h33; PCD = 32'h100; RegWD = 1; ALUCtrlD = 4'h5; ALUSrcD = 1;
    step();
    check("cap_RegS1E", RegS1E, 1);
    check("cap_RegS2E", RegS2E, 9);
    check("cap_WriteRegE", WriteRegE, 9);
    check("cap_RD1E", RD1E, 32'h11);
    check("cap_RD2E", RD2E, 32'h22);
    check("cap_ImmE", ImmE, 32'h33);
    check("cap_PCE", PCE, 32'h100);
    check("cap_RegWE", RegWE, 1);
    check("cap_ValidE", ValidE, 1);
    check("cap_ALUCtrlE", ALUCtrlE, 4'h5);
    check("cap_ALUSrcE", ALUSrcE, 1);

    // invalid decode slot: controls dropped, registers still copied
    clearD();
    ValidD = 0; RegWD = 1; MemReadD = 1; MemWD = 1; ALUCtrlD = 4'hA; ALUSrcD = 1;
    WriteRegD = 5'd3; RegS1D = 5'd6;
    step();
    check("inv_ValidE", ValidE, 0);
    check("inv_RegWE", RegWE, 0);
    check("inv_MemReadE", MemReadE, 0);
    check("inv_MemWE", MemWE, 0);
    check("inv_ALUCtrlE", ALUCtrlE, 0);
    check("inv_WriteRegE", WriteRegE, 3);
    check("inv_RegS1E", RegS1E, 6);

    // 3. load-use on src2
    driveLoad(5'd9);
    step();
    check("lu_loadMemReadE", MemReadE, 1);
    clearD();
    ValidD = 1; UsesS2D = 1; RegS2D = 9; UsesS1D = 1; RegS1D = 3; WriteRegD = 10;
    RegWD = 1; RD1D = 32'h44;
    #1;
    check("lu_StallD", StallD, 1);
    step();
    check("lu_bub_ValidE", ValidE, 0);
    check("lu_bub_RegWE", RegWE, 0);
    check("lu_bub_WriteRegE", WriteRegE, 0);
    check("lu_bub_RD1E", RD1E, 0);
    check("lu_StallCount1", StallCount, 1);
    check("lu_StallD_after", StallD, 0);
    step();
    check("lu_cap_ValidE", ValidE, 1);
    check("lu_cap_WriteRegE", WriteRegE, 10);
    check("lu_cap_RD1E", RD1E, 32'h44);
    check("lu_cap_RegWE", RegWE, 1);
    check("lu_StallCount_hold", StallCount, 1);

    // 4a. load to x0 never stalls
    driveLoad(5'd0);
    step();
    check("x0load_RegWE", RegWE, 0);
    check("x0load_MemReadE", MemReadE, 1);
    driveUser(5'd0);
    #1;
    check("x0load_StallD", StallD, 0);

    // 4b. register match but not used; then ValidD=0; then real match vs flush
    driveLoad(5'd4);
    step();
    clearD();
    ValidD = 1; RegS1D = 4; UsesS1D = 0; RegS2D = 5; UsesS2D = 1;
    #1;
    check("nouse_StallD", StallD, 0);
    UsesS1D = 1; ValidD = 0;
    #1;
    check("invD_StallD", StallD, 0);
    ValidD = 1;
    #1;
    check("use_StallD", StallD, 1);
    // 5. flush overrides stall
    FlushE = 1;
    #1;
    check("flush_StallD", StallD, 0);
    step();
    check("flush_ValidE", ValidE, 0);
    check("flush_WriteRegE", WriteRegE, 0);
    check("flush_StallCount", StallCount, 1);

    // 6. saturation on the 4-bit instance (it has also seen one stall so far)
    for (int i = 0; i < 13; i++) doStall();
    check("sat_small_pre", sStallCount, 4'hE);
    for (int i = 0; i < 3; i++) doStall();
    check("sat_small", sStallCount, 4'hF);
    check("sat_wide", StallCount, 17);

    // x0 destination never writes
    clearD();
    ValidD = 1; WriteRegD = 0; RegWD = 1;
    step();
    check("x0w_RegWE", RegWE, 0);
    check("x0w_ValidE", ValidE, 1);

    // reset in the middle of a stall wins
    driveLoad(5'd8);
    step();
    driveUser(5'd8);
    #1;
    check("rststall_StallD", StallD, 1);
    rst = 1;
    step();
    check("rststall_ValidE", ValidE, 0);
    check("rststall_MemReadE", MemReadE, 0);
    check("rststall_StallCount", StallCount, 0);
    check("rststall_sStallCount", sStallCount, 0);
    rst = 0;
    clearD();
    step();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
